// File: rtl/tick_scheduler.sv
// Run/halt/step/burst controller for the system tick. A reloadable countdown
// divider produces a one-cycle clock-enable pulse, gated by the current run mode.
module tick_scheduler #(
    parameter int NrOfBits      = 16,
    parameter int DefaultReload = 1,
    parameter int BurstBits     = 8
) (
    input  logic                 FPGAClock,
    input  logic                 FPGAReset,
    input  logic                 CfgWrite,
    input  logic [NrOfBits-1:0]  CfgReload,
    input  logic                 RunReq,
    input  logic                 HaltReq,
    input  logic                 StepReq,
    input  logic                 BurstReq,
    input  logic [BurstBits-1:0] BurstCount,
    output logic                 FPGATick,
    output logic                 Running,
    output logic [BurstBits-1:0] Remaining
);

    typedef enum logic [1:0] {
        ST_HALT,
        ST_RUN,
        ST_STEP,
        ST_BURST
    } state_e;

    localparam logic [NrOfBits-1:0]  ONE_R        = NrOfBits'(1);
    localparam logic [BurstBits-1:0] ONE_B        = BurstBits'(1);
    localparam logic [NrOfBits-1:0]  RESET_RELOAD = (DefaultReload == 0) ? ONE_R
                                                                          : NrOfBits'(DefaultReload);

    state_e                 state_q, state_d;
    logic [NrOfBits-1:0]    reload_q, reload_d;
    logic [NrOfBits-1:0]    counter_q, counter_d;
    logic [BurstBits-1:0]   remaining_q, remaining_d;
    logic                   tick_q, tick_d;
    logic                   running_q, running_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case/if tree leaves it unassigned, which would infer a latch.
        reload_d    = reload_q;
        state_d     = state_q;
        counter_d   = counter_q;
        remaining_d = remaining_q;
        tick_d      = 1'b0;

        // A zero reload would stall the divider, so it is stored as 1.
        if (CfgWrite) begin
            reload_d = (CfgReload == '0) ? ONE_R : CfgReload;
        end

        case (state_q)
            ST_HALT: begin
                if (!HaltReq) begin
                    if (RunReq) begin
                        state_d     = ST_RUN;
                        counter_d   = reload_d - ONE_R;
                        remaining_d = '0;
                    end else if (StepReq) begin
                        state_d     = ST_STEP;
                        counter_d   = reload_d - ONE_R;
                        remaining_d = ONE_B;
                    end else if (BurstReq && BurstCount != '0) begin
                        state_d     = ST_BURST;
                        counter_d   = reload_d - ONE_R;
                        remaining_d = BurstCount;
                    end
                end
            end
            default: begin
                if (HaltReq) begin
                    state_d     = ST_HALT;
                    remaining_d = '0;
                end else if (CfgWrite) begin
                    // Restart the interval at the new rate; no tick this edge.
                    counter_d = reload_d - ONE_R;
                end else if (counter_q == '0) begin
                    tick_d    = 1'b1;
                    counter_d = reload_q - ONE_R;
                    if (state_q == ST_STEP) begin
                        state_d     = ST_HALT;
                        remaining_d = '0;
                    end else if (state_q == ST_BURST) begin
                        if (remaining_q == ONE_B) begin
                            state_d     = ST_HALT;
                            remaining_d = '0;
                        end else begin
                            remaining_d = remaining_q - ONE_B;
                        end
                    end
                end else begin
                    counter_d = counter_q - ONE_R;
                end
            end
        endcase

        running_d = (state_d != ST_HALT);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge FPGAClock) begin
        if (FPGAReset) begin
            state_q     <= ST_HALT;
            reload_q    <= RESET_RELOAD;
            counter_q   <= '0;
            remaining_q <= '0;
            tick_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            reload_q    <= reload_d;
            counter_q   <= counter_d;
            remaining_q <= remaining_d;
            tick_q      <= tick_d;
            running_q   <= running_d;
        end
    end

    assign FPGATick  = tick_q;
    assign Running   = running_q;
    assign Remaining = remaining_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed self-checking bench for tick_scheduler: reset, run, step, burst,
// halt suppression, zero-reload reconfiguration and mid-run reset.
module tb_tick_scheduler;

    logic        FPGAClock;
    logic        FPGAReset;
    logic        CfgWrite;
    logic [15:0] CfgReload;
    logic        RunReq;
    logic        HaltReq;
    logic        StepReq;
    logic        BurstReq;
    logic [7:0]  BurstCount;
    logic        FPGATick;
    logic        Running;
    logic [7:0]  Remaining;

    int tests  = 0;
    int failed = 0;

    tick_scheduler #(
        .NrOfBits      (16),
        .DefaultReload (1),
        .BurstBits     (8)
    ) dut (
        .FPGAClock  (FPGAClock),
        .FPGAReset  (FPGAReset),
        .CfgWrite   (CfgWrite),
        .CfgReload  (CfgReload),
        .RunReq     (RunReq),
        .HaltReq    (HaltReq),
        .StepReq    (StepReq),
        .BurstReq   (BurstReq),
        .BurstCount (BurstCount),
        .FPGATick   (FPGATick),
        .Running    (Running),
        .Remaining  (Remaining)
    );

    initial FPGAClock = 1'b0;
    always #5 FPGAClock = ~FPGAClock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One active edge; inputs are driven and outputs sampled on the falling edge.
    task automatic cyc();
        @(posedge FPGAClock);
        @(negedge FPGAClock);
    endtask

    task automatic count_ticks(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (FPGATick === 1'b1) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        FPGAReset  = 1'b1;
        CfgWrite   = 1'b0;
        CfgReload  = '0;
        RunReq     = 1'b0;
        HaltReq    = 1'b0;
        StepReq    = 1'b0;
        BurstReq   = 1'b0;
        BurstCount = '0;
        cyc();
        cyc();
        FPGAReset = 1'b0;

        // Reset state and idle behaviour.
        check("rst_tick", FPGATick, 1'b0);
        check("rst_running", Running, 1'b0);
        check("rst_remaining", Remaining, 8'd0);
        count_ticks(20, cnt);
        check("idle_ticks", cnt, 0);
        check("idle_running", Running, 1'b0);

        // Free run at R=4; requests other than halt are ignored while running.
        CfgWrite = 1'b1; CfgReload = 16'd4;
        cyc();
        CfgWrite = 1'b0;
        RunReq = 1'b1;
        cyc();
        RunReq = 1'b0;
        check("run_e0_running", Running, 1'b1);
        check("run_e0_remaining", Remaining, 8'd0);
        check("run_e0_tick", FPGATick, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            if (k == 6) begin
                BurstReq = 1'b1; BurstCount = 8'd5; StepReq = 1'b1;
            end
            cyc();
            BurstReq = 1'b0; StepReq = 1'b0;
            check($sformatf("run_tick_k%0d", k), FPGATick, (k % 4 == 0));
            check($sformatf("run_rem_k%0d", k), Remaining, 8'd0);
        end
        check("run_running", Running, 1'b1);

        // Halt, then a single step at R=3.
        HaltReq = 1'b1;
        cyc();
        HaltReq = 1'b0;
        check("halt_running", Running, 1'b0);
        check("halt_tick", FPGATick, 1'b0);
        CfgWrite = 1'b1; CfgReload = 16'd3;
        cyc();
        CfgWrite = 1'b0;
        StepReq = 1'b1;
        cyc();
        StepReq = 1'b0;
        check("step_e0_running", Running, 1'b1);
        check("step_e0_remaining", Remaining, 8'd1);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            check($sformatf("step_tick_k%0d", k), FPGATick, (k == 3));
            check($sformatf("step_rem_k%0d", k), Remaining, (k == 3) ? 8'd0 : 8'd1);
            check($sformatf("step_run_k%0d", k), Running, (k != 3));
        end
        count_ticks(20, cnt);
        check("step_after_ticks", cnt, 0);

        // Burst of 3 at R=2, with the reload written in the accepting cycle.
        CfgWrite = 1'b1; CfgReload = 16'd2;
        BurstReq = 1'b1; BurstCount = 8'd3;
        cyc();
        CfgWrite = 1'b0; BurstReq = 1'b0;
        check("burst3_e0_running", Running, 1'b1);
        check("burst3_e0_remaining", Remaining, 8'd3);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            check($sformatf("burst3_tick_k%0d", k), FPGATick, (k % 2 == 0));
            check($sformatf("burst3_rem_k%0d", k), Remaining, 8'(3 - k / 2));
        end
        check("burst3_running", Running, 1'b0);
        count_ticks(8, cnt);
        check("burst3_after_ticks", cnt, 0);

        // Zero-length burst request is ignored.
        BurstReq = 1'b1; BurstCount = 8'd0;
        cyc();
        BurstReq = 1'b0;
        check("burst0_running", Running, 1'b0);
        check("burst0_remaining", Remaining, 8'd0);
        count_ticks(6, cnt);
        check("burst0_ticks", cnt, 0);

        // Burst of 10 at R=5, halted (with a competing RunReq) just before tick 3.
        CfgWrite = 1'b1; CfgReload = 16'd5;
        cyc();
        CfgWrite = 1'b0;
        BurstReq = 1'b1; BurstCount = 8'd10;
        cyc();
        BurstReq = 1'b0;
        check("burst10_e0_remaining", Remaining, 8'd10);
        for (int k = 1; k <= 14; k++) begin
            cyc();
            check($sformatf("burst10_tick_k%0d", k), FPGATick, (k == 5 || k == 10));
            check($sformatf("burst10_rem_k%0d", k), Remaining,
                  (k < 5) ? 8'd10 : (k < 10) ? 8'd9 : 8'd8);
        end
        HaltReq = 1'b1; RunReq = 1'b1;
        cyc();
        HaltReq = 1'b0; RunReq = 1'b0;
        check("burst10_halt_tick", FPGATick, 1'b0);
        check("burst10_halt_running", Running, 1'b0);
        check("burst10_halt_remaining", Remaining, 8'd0);
        count_ticks(10, cnt);
        check("burst10_after_ticks", cnt, 0);
        check("burst10_after_running", Running, 1'b0);

        // Run at R=8, then reload written as 0 mid-interval gives R=1.
        CfgWrite = 1'b1; CfgReload = 16'd8;
        cyc();
        CfgWrite = 1'b0;
        RunReq = 1'b1;
        cyc();
        RunReq = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            check($sformatf("r8_tick_k%0d", k), FPGATick, 1'b0);
        end
        CfgWrite = 1'b1; CfgReload = 16'd0;
        cyc();
        CfgWrite = 1'b0;
        check("r0_write_tick", FPGATick, 1'b0);
        check("r0_write_running", Running, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check($sformatf("r1_tick_k%0d", k), FPGATick, 1'b1);
        end

        // Reset mid-run clears outputs and restores the default reload.
        FPGAReset = 1'b1;
        cyc();
        FPGAReset = 1'b0;
        check("mrst_tick", FPGATick, 1'b0);
        check("mrst_running", Running, 1'b0);
        check("mrst_remaining", Remaining, 8'd0);
        cyc();
        check("mrst_after_tick", FPGATick, 1'b0);
        CfgWrite = 1'b0;
        RunReq = 1'b1;
        cyc();
        RunReq = 1'b0;
        check("mrst_run_tick_e0", FPGATick, 1'b0);
        cyc();
        check("mrst_run_tick_k1", FPGATick, 1'b1);
        cyc();
        check("mrst_run_tick_k2", FPGATick, 1'b1);
        check("mrst_run_running", Running, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
